// File: rtl/cr_gen_sequencer_pkg.sv
// Shared types and helper functions for the correlated-random generator
// job sequencer: widths, job fields, FSM state encoding, lane decode and
// carry-mask construction.
package cr_gen_sequencer_pkg;

  localparam int LEN_PRNG   = 256;
  localparam int LEN_KEY    = 128;
  localparam int LEN_MAX_CR = 32;
  localparam int WORDS      = LEN_PRNG / 32;

  typedef logic [LEN_KEY-1:0]    key_t;
  typedef logic [2:0]            mode_t;
  typedef logic [2:0]            width_t;   // {is256, is128, is64}
  typedef logic [LEN_PRNG-1:0]   prng_t;
  typedef logic [LEN_MAX_CR-1:0] cr_cnt_t;
  typedef logic [WORDS-1:0]      word_mask_t;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    INIT = 3'd1,
    REQ  = 3'd2,
    OUT  = 3'd3,
    DONE = 3'd4
  } cr_seq_state_t;

  // Priority decode of the one-hot-ish width code into CRs per block.
  function automatic logic [3:0] lanes_per_block(input width_t w);
    if (w[2])      return 4'd1;
    else if (w[1]) return 4'd2;
    else if (w[0]) return 4'd4;
    else           return 4'd8;
  endfunction

  // Marks the top bit of every lane except the last: carries out of
  // those bits must not ripple into the neighbouring lane.
  function automatic prng_t make_carry_mask(input width_t w);
    prng_t m;
    int    l;
    int    lw;
    m  = '0;
    l  = int'(lanes_per_block(w));
    lw = LEN_PRNG / l;
    for (int j = 1; j < 8; j++) begin
      if (j < l) m[j*lw-1] = 1'b1;
    end
    return m;
  endfunction

endpackage

// File: rtl/cr_gen_sequencer_mask.sv
// Combinational word-mask generator: how many CRs of the current width
// fit in the next block and which 32-bit words they occupy.
module cr_word_mask_gen
  import cr_gen_sequencer_pkg::*;
(
  input  width_t     i_width,
  input  cr_cnt_t    i_remaining,
  output logic [3:0] o_n,
  output word_mask_t o_mask
);

  logic [3:0] w_lanes;
  logic [3:0] w_bits;

  // n = min(remaining, lanes); mask covers n CRs of 8/lanes words each
  always_comb begin
    w_lanes = lanes_per_block(i_width);
    o_n     = w_lanes;
    if (i_remaining < {28'd0, w_lanes}) o_n = i_remaining[3:0];
    w_bits = o_n * (4'd8 / w_lanes);
    if (o_n == w_lanes) o_mask = 8'hFF;
    else                o_mask = word_mask_t'((9'd1 << w_bits) - 9'd1);
  end

endmodule

// File: rtl/cr_gen_sequencer.sv
// Job sequencer in front of the 256-bit PRNG core. Keys the PRNG once per
// job, pulls blocks, forwards them with word/carry masks and counts CRs
// down to zero. Optional statistics counters are enabled by defining
// CR_STATS_EN.
module cr_gen_sequencer
  import cr_gen_sequencer_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start_i,
  input  key_t       key_i,
  input  mode_t      mode_i,
  input  width_t     width_i,
  input  cr_cnt_t    num_cr_i,
  input  logic       abort_i,
  output logic       prng_init_o,
  output key_t       prng_key_o,
  output logic       prng_req_o,
  input  logic       prng_valid_i,
  input  prng_t      prng_data_i,
  output logic       cr_valid_o,
  input  logic       cr_ready_i,
  output prng_t      cr_data_o,
  output word_mask_t cr_word_mask_o,
  output prng_t      cr_carry_mask_o,
  output mode_t      cr_mode_o,
  output logic       busy_o,
  output logic       done_o
`ifdef CR_STATS_EN
  ,
  output logic [31:0] stat_blocks_o,
  output logic [15:0] stat_jobs_o
`endif
);

  cr_seq_state_t r_state;
  cr_seq_state_t w_next;

  key_t       r_key;
  mode_t      r_mode;
  width_t     r_width;
  prng_t      r_carry_mask;
  cr_cnt_t    r_remaining;
  prng_t      r_data;
  word_mask_t r_word_mask;

  logic       w_accept;
  logic       w_capture;
  logic [3:0] w_n;
  word_mask_t w_mask;

  cr_word_mask_gen u_mask_gen (
    .i_width     (r_width),
    .i_remaining (r_remaining),
    .o_n         (w_n),
    .o_mask      (w_mask)
  );

  assign w_accept  = (r_state == IDLE) && start_i;
  // A block arriving together with abort is discarded.
  assign w_capture = (r_state == REQ) && prng_valid_i && !abort_i;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_next;
  end

  // Next-state logic; abort wins in every busy state except DONE
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE: if (start_i) w_next = (num_cr_i != '0) ? INIT : DONE;
      INIT: w_next = abort_i ? DONE : REQ;
      REQ: begin
        if (abort_i)           w_next = DONE;
        else if (prng_valid_i) w_next = OUT;
      end
      OUT: begin
        if (abort_i)         w_next = DONE;
        else if (cr_ready_i) w_next = (r_remaining == '0) ? DONE : REQ;
      end
      DONE:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // Job latch at start and block capture / CR countdown on each PRNG ack
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_key        <= '0;
      r_mode       <= '0;
      r_width      <= '0;
      r_carry_mask <= '0;
      r_remaining  <= '0;
      r_data       <= '0;
      r_word_mask  <= '0;
    end else if (w_accept) begin
      r_key        <= key_i;
      r_mode       <= mode_i;
      r_width      <= width_i;
      r_carry_mask <= make_carry_mask(width_i);
      r_remaining  <= num_cr_i;
    end else if (w_capture) begin
      r_data       <= prng_data_i;
      r_word_mask  <= w_mask;
      r_remaining  <= r_remaining - {28'd0, w_n};
    end
  end

  assign prng_init_o     = (r_state == INIT);
  assign prng_req_o      = (r_state == REQ);
  assign cr_valid_o      = (r_state == OUT);
  assign done_o          = (r_state == DONE);
  assign busy_o          = (r_state != IDLE);
  assign prng_key_o      = r_key;
  assign cr_mode_o       = r_mode;
  assign cr_data_o       = r_data;
  assign cr_word_mask_o  = r_word_mask;
  assign cr_carry_mask_o = r_carry_mask;

`ifdef CR_STATS_EN
  logic [31:0] r_stat_blocks;
  logic [15:0] r_stat_jobs;

  // Free-running wrap-around counters of delivered blocks and finished jobs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_stat_blocks <= '0;
      r_stat_jobs   <= '0;
    end else begin
      if (cr_valid_o && cr_ready_i) r_stat_blocks <= r_stat_blocks + 32'd1;
      if (done_o)                   r_stat_jobs   <= r_stat_jobs + 16'd1;
    end
  end

  assign stat_blocks_o = r_stat_blocks;
  assign stat_jobs_o   = r_stat_jobs;
`endif

endmodule
